// File: rtl/alu_md.sv
// alu_md: single-issue ALU with an iterative multiply/divide unit.
// Base operations complete in one cycle; multiply/divide iterate one bit per
// cycle for OPERAND_LENGTH cycles. Results are held in DONE until taken.
module alu_md #(
    parameter int OPERAND_LENGTH = 32,
    parameter int PC_LENGTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPERAND_LENGTH-1:0] opd1,
    input  logic [OPERAND_LENGTH-1:0] opd2,
    input  logic [OPERAND_LENGTH-1:0] opd3,
    input  logic [OPERAND_LENGTH-1:0] opd4,
    input  logic [PC_LENGTH-1:0]      pc,
    input  logic                      alu_mux1_select,
    input  logic [1:0]                alu_mux2_select,
    input  logic [3:0]                alu_op_select,
    input  logic                      alu_pc_select,
    input  logic                      md_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPERAND_LENGTH-1:0] alu_result,
    output logic [OPERAND_LENGTH-1:0] comp_result
);

    localparam int W  = OPERAND_LENGTH;
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    result_q, result_d;
    logic            comp_q, comp_d;
    logic [2*W-1:0]  acc_q, acc_d;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [W-1:0]    b_q, b_d;          // multiplicand / divisor magnitude
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;      // negate the selected result at the end
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            fire;

    // Base ALU datapath signals
    logic [W-1:0]    pc_ext;
    logic [W-1:0]    add_a;
    logic [W-1:0]    add_res;
    logic [W-1:0]    logic_res;
    logic [SW-1:0]   shamt;
    logic [W-1:0]    shift_res;
    logic [W-1:0]    cmp_x, cmp_y;
    logic            cmp_bit;
    logic [W-1:0]    base_res;
    logic            base_cmp;

    // Multiply/divide setup and iteration signals
    logic            sgn_a, sgn_b;
    logic            a_neg, b_neg;
    logic [W-1:0]    a_abs, b_abs;
    logic            neg_init;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_part;
    logic            div_ge;
    logic [W-1:0]    div_diff;
    logic [2*W-1:0]  div_next;
    logic [2*W-1:0]  step;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    md_res;

    assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign fire        = in_valid && in_ready;
    assign out_valid   = (state_q == DONE);
    assign alu_result  = result_q;
    assign comp_result = {{(W-1){1'b0}}, comp_q};

    // Single-cycle base ALU: adder, logic, shifter and comparator on live inputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        pc_ext                 = '0;
        pc_ext[PC_LENGTH-1:0]  = pc;
        add_a                  = alu_pc_select ? pc_ext : opd1;
        add_res                = alu_op_select[3] ? (add_a - opd2) : (add_a + opd2);

        logic_res = '0;
        case (alu_op_select)
            4'b0000: logic_res = ~opd1;
            4'b0001: logic_res = ~opd2;
            4'b0111: logic_res = opd1 & opd2;
            4'b0110: logic_res = opd1 | opd2;
            4'b0100: logic_res = opd1 ^ opd2;
            default: logic_res = '0;
        endcase

        shamt     = opd2[SW-1:0];
        shift_res = '0;
        case (alu_op_select)
            4'b0011: shift_res = opd1 << shamt;
            4'b0001: shift_res = opd1 >> shamt;
            4'b0111: shift_res = $unsigned($signed(opd1) >>> shamt);
            default: shift_res = '0;
        endcase

        cmp_x   = alu_mux1_select ? opd3 : opd1;
        cmp_y   = alu_mux1_select ? opd4 : opd2;
        cmp_bit = 1'b0;
        case (alu_op_select)
            4'b0000: cmp_bit = (cmp_x == cmp_y);
            4'b0001: cmp_bit = (cmp_x != cmp_y);
            4'b0010: cmp_bit = ($signed(cmp_x) >= $signed(cmp_y));
            4'b0110: cmp_bit = (cmp_x >= cmp_y);
            4'b0011: cmp_bit = ($signed(cmp_x) <  $signed(cmp_y));
            4'b0111: cmp_bit = (cmp_x <  cmp_y);
            default: cmp_bit = 1'b0;
        endcase

        base_cmp = 1'b0;
        case (alu_mux2_select)
            2'b00:   base_res = add_res;
            2'b01:   base_res = logic_res;
            2'b10:   base_res = shift_res;
            default: begin
                base_res = {{(W-1){1'b0}}, cmp_bit};
                base_cmp = cmp_bit;
            end
        endcase
    end

    // Multiply/divide operand conditioning: work on magnitudes, remember final sign.
    always_comb begin
        a_neg = opd1[W-1];
        b_neg = opd2[W-1];
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (alu_op_select[2:0])
            3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            3'b010:                 sgn_a = 1'b1;
            default: ;
        endcase
        a_abs = (sgn_a && a_neg) ? (~opd1 + 1'b1) : opd1;
        b_abs = (sgn_b && b_neg) ? (~opd2 + 1'b1) : opd2;

        neg_init = 1'b0;
        case (alu_op_select[2:0])
            3'b001, 3'b010: neg_init = (sgn_a && a_neg) ^ (sgn_b && b_neg);
            // A zero divisor leaves the all-ones quotient magnitude un-negated.
            3'b100:         neg_init = (a_neg ^ b_neg) && (opd2 != '0);
            3'b110:         neg_init = a_neg;
            default:        neg_init = 1'b0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide, plus result fix-up.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        mul_next = {mul_sum, acc_q[W-1:1]};

        div_part = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge   = (div_part >= {1'b0, b_q});
        div_diff = div_part[W-1:0] - b_q;
        div_next = {(div_ge ? div_diff : div_part[W-1:0]), acc_q[W-2:0], div_ge};

        step     = op_q[2] ? div_next : mul_next;
        prod_fix = neg_q ? -step : step;

        case (op_q)
            3'b000:                 md_res = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: md_res = prod_fix[2*W-1:W];
            3'b100, 3'b101:         md_res = neg_q ? -step[W-1:0] : step[W-1:0];
            default:                md_res = neg_q ? -step[2*W-1:W] : step[2*W-1:W];
        endcase
    end

    // Next-state logic: accept requests, iterate in BUSY, hold the result in DONE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        comp_d   = comp_q;
        acc_d    = acc_q;
        b_d      = b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
                if (fire) begin
                    if (md_en) begin
                        state_d = BUSY;
                        acc_d   = {{W{1'b0}}, a_abs};
                        b_d     = b_abs;
                        op_d    = alu_op_select[2:0];
                        neg_d   = neg_init;
                        cnt_d   = '0;
                    end else begin
                        state_d  = DONE;
                        result_d = base_res;
                        comp_d   = base_cmp;
                    end
                end
            end
            BUSY: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d  = DONE;
                    result_d = md_res;
                    comp_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            comp_q   <= 1'b0;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            result_q <= result_d;
            comp_q   <= comp_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed self-checking bench for alu_md at W=8, PC_LENGTH=4.
module tb_alu_md;

    localparam int W   = 8;
    localparam int PCL = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   opd1 = '0, opd2 = '0, opd3 = '0, opd4 = '0;
    logic [PCL-1:0] pc = '0;
    logic           alu_mux1_select = 1'b0;
    logic [1:0]     alu_mux2_select = 2'b00;
    logic [3:0]     alu_op_select = 4'b0000;
    logic           alu_pc_select = 1'b0;
    logic           md_en = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   alu_result;
    logic [W-1:0]   comp_result;

    int n_checks = 0;
    int n_errors = 0;

    alu_md #(.OPERAND_LENGTH(W), .PC_LENGTH(PCL)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .opd1            (opd1),
        .opd2            (opd2),
        .opd3            (opd3),
        .opd4            (opd4),
        .pc              (pc),
        .alu_mux1_select (alu_mux1_select),
        .alu_mux2_select (alu_mux2_select),
        .alu_op_select   (alu_op_select),
        .alu_pc_select   (alu_pc_select),
        .md_en           (md_en),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .alu_result      (alu_result),
        .comp_result     (comp_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, perturb inputs after transfer, wait for out_valid, check.
    task automatic run(input string tag, input logic md, input logic [1:0] mux2,
                       input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input logic [W-1:0] exp_cmp,
                       input int exp_lat);
        int lat;
        @(negedge clk);
        opd1            = a;
        opd2            = b;
        md_en           = md;
        alu_mux2_select = mux2;
        alu_op_select   = op;
        out_ready       = 1'b1;
        in_valid        = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid      = 1'b0;
        opd1          = ~a;
        opd2          = ~b;
        alu_op_select = ~op;
        md_en         = ~md;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, 32'(alu_result), 32'(exp_res));
        check({tag, "_comp"}, 32'(comp_result), 32'(exp_cmp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;

        // Reset state, before any clock edge
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_result", 32'(alu_result), 32'd0);
        check("rst_comp_result", 32'(comp_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Adder
        run("add", 1'b0, 2'b00, 4'b0000, 8'h03, 8'h08, 8'h0B, 8'h00, 1);
        pc = 4'h1; alu_pc_select = 1'b1;
        run("add_pc", 1'b0, 2'b00, 4'b0000, 8'h03, 8'h08, 8'h09, 8'h00, 1);
        alu_pc_select = 1'b0;
        run("sub", 1'b0, 2'b00, 4'b1000, 8'h0A, 8'h0C, 8'hFE, 8'h00, 1);

        // Logic
        run("and", 1'b0, 2'b01, 4'b0111, 8'hCC, 8'hFF, 8'hCC, 8'h00, 1);
        run("or",  1'b0, 2'b01, 4'b0110, 8'hCC, 8'hFF, 8'hFF, 8'h00, 1);
        run("xor", 1'b0, 2'b01, 4'b0100, 8'hCC, 8'hFF, 8'h33, 8'h00, 1);
        run("not1", 1'b0, 2'b01, 4'b0000, 8'hCC, 8'hFF, 8'h33, 8'h00, 1);

        // Shifter
        run("sra3", 1'b0, 2'b10, 4'b0111, 8'h60, 8'h03, 8'h0C, 8'h00, 1);
        run("sra0", 1'b0, 2'b10, 4'b0111, 8'hE0, 8'h00, 8'hE0, 8'h00, 1);
        run("sll1", 1'b0, 2'b10, 4'b0011, 8'h81, 8'h01, 8'h02, 8'h00, 1);
        run("srl3", 1'b0, 2'b10, 4'b0001, 8'h81, 8'h0B, 8'h10, 8'h00, 1);

        // Comparison on opd3/opd4 (opd1/opd2 chosen to disagree)
        opd3 = 8'hFF; opd4 = 8'hFC; alu_mux1_select = 1'b1;
        run("lt_p2",  1'b0, 2'b11, 4'b0011, 8'h00, 8'h01, 8'h00, 8'h00, 1);
        run("ltu_p2", 1'b0, 2'b11, 4'b0111, 8'h00, 8'h01, 8'h00, 8'h00, 1);
        run("ge_p2",  1'b0, 2'b11, 4'b0010, 8'h00, 8'h01, 8'h01, 8'h01, 1);
        run("ne_p2",  1'b0, 2'b11, 4'b0001, 8'h00, 8'h01, 8'h01, 8'h01, 1);
        alu_mux1_select = 1'b0;
        run("lt_p1",  1'b0, 2'b11, 4'b0011, 8'h00, 8'h01, 8'h01, 8'h01, 1);
        run("eq_p1",  1'b0, 2'b11, 4'b0000, 8'h05, 8'h05, 8'h01, 8'h01, 1);

        // Multiply/divide (mux2=11 shows md_en overrides the result source)
        run("mul",    1'b1, 2'b11, 4'b0000, 8'hFD, 8'h03, 8'hF7, 8'h00, 9);
        run("mulh",   1'b1, 2'b11, 4'b0001, 8'hFD, 8'h03, 8'hFF, 8'h00, 9);
        run("mulhu",  1'b1, 2'b11, 4'b0011, 8'hFD, 8'h03, 8'h02, 8'h00, 9);
        run("mulhsu", 1'b1, 2'b11, 4'b0010, 8'hFD, 8'hFF, 8'hFD, 8'h00, 9);
        run("div_ovf", 1'b1, 2'b11, 4'b0100, 8'h80, 8'hFF, 8'h80, 8'h00, 9);
        run("rem_ovf", 1'b1, 2'b11, 4'b0110, 8'h80, 8'hFF, 8'h00, 8'h00, 9);
        run("divu_z",  1'b1, 2'b11, 4'b0101, 8'h07, 8'h00, 8'hFF, 8'h00, 9);
        run("remu_z",  1'b1, 2'b11, 4'b0111, 8'h07, 8'h00, 8'h07, 8'h00, 9);
        run("div_z",   1'b1, 2'b11, 4'b0100, 8'hF9, 8'h00, 8'hFF, 8'h00, 9);
        run("rem_z",   1'b1, 2'b11, 4'b0110, 8'hF9, 8'h00, 8'hF9, 8'h00, 9);
        run("div_neg", 1'b1, 2'b11, 4'b0100, 8'hF9, 8'h02, 8'hFD, 8'h00, 9);
        run("rem_neg", 1'b1, 2'b11, 4'b0110, 8'hF9, 8'h02, 8'hFF, 8'h00, 9);
        run("divu",    1'b1, 2'b11, 4'b0101, 8'h64, 8'h07, 8'h0E, 8'h00, 9);
        run("remu",    1'b1, 2'b11, 4'b0111, 8'h64, 8'h07, 8'h02, 8'h00, 9);

        // Backpressure: 5+6 held in DONE, then back-to-back 0x20-0x01
        @(negedge clk);
        opd1 = 8'h05; opd2 = 8'h06; md_en = 1'b0;
        alu_mux2_select = 2'b00; alu_op_select = 4'b0000;
        out_ready = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_valid0", 32'(out_valid), 32'd1);
        check("bp_result0", 32'(alu_result), 32'h0B);
        held = alu_result;
        for (int i = 0; i < 3; i++) begin
            opd1 = 8'(i + 8'h40);
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", 32'(alu_result), 32'(held));
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        opd1 = 8'h20; opd2 = 8'h01; alu_op_select = 4'b1000;
        out_ready = 1'b1; in_valid = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_result", 32'(alu_result), 32'h1F);

        // Reset at BUSY cycle 4 of a DIV
        @(negedge clk);
        opd1 = 8'h64; opd2 = 8'h07; md_en = 1'b1; alu_op_select = 4'b0100;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; md_en = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstb_out_valid", 32'(out_valid), 32'd0);
        check("rstb_in_ready", 32'(in_ready), 32'd1);
        check("rstb_result", 32'(alu_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("add_after_rst", 1'b0, 2'b00, 4'b0000, 8'h21, 8'h12, 8'h33, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter OPERAND_LENGTH, default 32, operand and result width W; SHALL be an even number of at least 4.
REQ-002 Parameter PC_LENGTH, default 32, program counter width; SHALL be at most OPERAND_LENGTH.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present; in_ready  output  1  block can accept a request.
REQ-006 opd1, opd2, opd3, opd4  input  W each  operands.
REQ-007 pc  input  PC_LENGTH  program counter, zero-extended to W where used.
REQ-008 alu_mux1_select  input  1  comparison operand pair: 0 selects opd1/opd2, 1 selects opd3/opd4.
REQ-009 alu_mux2_select  input  2  result source: 00 adder, 01 logic, 10 shifter, 11 comparison.
REQ-010 alu_op_select  input  4  operation code within the selected unit.
REQ-011 alu_pc_select  input  1  adder first operand: 0 selects opd1, 1 selects pc.
REQ-012 md_en  input  1  1 selects the multiply/divide unit and overrides alu_mux2_select.
REQ-013 out_valid  output  1  result present; out_ready  input  1  consumer takes the result.
REQ-014 alu_result  output  W  registered result; comp_result  output  W  registered comparison flag, zero-extended.

Function
REQ-015 A request SHALL transfer on a clock edge where in_valid and in_ready are both 1; all request inputs SHALL be captured on that edge.
REQ-016 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-017 in_ready SHALL equal 1 in IDLE, and in DONE when out_ready is 1; in_ready SHALL be 0 in BUSY.
REQ-018 A base operation (md_en=0) SHALL go directly to DONE, with out_valid asserted the cycle after the transfer (latency 1).
REQ-019 A multiply/divide operation (md_en=1) SHALL go to BUSY for exactly W cycles, then to DONE; out_valid SHALL rise W+1 cycles after the transfer.
REQ-020 In DONE, out_valid, alu_result and comp_result SHALL be held stable while out_ready is 0.
REQ-021 DONE with out_ready=1 SHALL go to IDLE, or, if a new request transfers on the same edge, to DONE or BUSY for that request (back-to-back, no bubble).
REQ-022 Adder: alu_op_select[3]=1 SHALL subtract, otherwise add; the result is modulo 2^W.
REQ-023 Logic: 0000 gives ~opd1, 0001 gives ~opd2, 0111 AND, 0110 OR, 0100 XOR; other codes give 0.
REQ-024 Shifter: 0011 SLL, 0001 SRL, 0111 SRA, applied to opd1 with shift amount opd2[log2(W)-1:0]; other codes give 0.
REQ-025 Comparison on the pair chosen by alu_mux1_select: 0000 EQ, 0001 NE, 0010 GE (signed), 0110 GEU, 0011 LT (signed), 0111 LTU; other codes give 0.
REQ-026 comparison result: alu_result SHALL equal comp_result; in all other modes comp_result SHALL be 0.
REQ-027 Multiply/divide operands SHALL be opd1 and opd2; alu_op_select[2:0] selects 000 MUL (low W bits), 001 MULH (signed x signed), 010 MULHSU (signed x unsigned), 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-028 Multiply SHALL be iterative shift-add with one bit per cycle; divide SHALL be iterative restoring with one bit per cycle; the iteration counter SHALL be ceil(log2(W))+1 bits wide.
REQ-029 Division by zero: the quotient SHALL be all ones and the remainder SHALL equal the dividend (signed and unsigned).
REQ-030 Signed overflow (-2^(W-1) / -1): the quotient SHALL equal the dividend and the remainder SHALL be 0.
REQ-031 The sign of a signed remainder SHALL follow the dividend; the sign of a signed quotient SHALL be negative when the operand signs differ.
REQ-032 Input changes while in BUSY or DONE SHALL NOT affect the result in flight.

Reset
REQ-033 When rst_n=0, the FSM SHALL go to IDLE, out_valid, alu_result, comp_result and all internal registers SHALL go to 0, and in_ready SHALL be 1, regardless of clk.
REQ-034 Reset asserted during BUSY or DONE SHALL discard the operation; after reset release, the first transfer SHALL behave normally.

Verification (W=8, PC_LENGTH=4)
REQ-035 Adder: opd1=3, opd2=8, op 0000, then pc=1 with alu_pc_select=1 -> 0x0B, then 0x09; each with out_valid one cycle after transfer.
REQ-036 Subtract and logic: 10-12 (op 1000) -> 0xFE; opd1=0xCC, opd2=0xFF, AND/OR/XOR -> 0xCC/0xFF/0x33; SRA of 0x60 by 3 -> 0x0C; SRA of 0xE0 by 0 -> 0xE0.
REQ-037 Comparison: opd3=0xFF, opd4=0xFC, mux1=1: LT -> 0, LTU -> 0, GE -> 1, NE -> 1, with alu_result equal to comp_result.
REQ-038 Multiply/divide: opd1=0xFD, opd2=0x03 -> MUL 0xF7, MULH 0xFF, MULHU 0x02; DIV 0x80/0xFF -> 0x80 and REM -> 0; DIVU 7/0 -> 0xFF and REMU -> 7; out_valid exactly 9 cycles after transfer.
REQ-039 Backpressure and back-to-back: hold out_ready=0 for 3 cycles in DONE -> result stable and in_ready=0; then out_ready=1 with a new in_valid -> new request accepted on the same edge.
REQ-040 Reset during BUSY at cycle 4 of a DIV -> out_valid=0 and in_ready=1 immediately; the next ADD completes with the correct result.
